// File: rtl/sys_ctrl_cmd_pkg.sv
// rtl/sys_ctrl_cmd_pkg.sv - shared types and command codes for the command sequencer
// Purpose: FSM state enumeration and the framed-command opcode bytes.
// Ports: none (package).
package sys_ctrl_cmd_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_ALU_A,
    S_ALU_B,
    S_ALU_FUN,
    S_ALU_WAIT,
    S_TX_LO,
    S_TX_HI
  } state_e;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

endpackage

// File: rtl/sys_ctrl_cmd_if.sv
// rtl/sys_ctrl_cmd_if.sv - bundle of RX, reg-file, ALU and TX signals around the sequencer
// Purpose: groups every non-clock/reset signal of sys_ctrl_cmd.
// Signals (named from the sequencer's point of view):
//   i_rx_data/i_rx_valid             received byte, 1-cycle valid pulse
//   o_rf_wr_en/o_rf_rd_en            reg-file write/read enable pulses
//   o_rf_addr/o_rf_wr_data           reg-file address and write data
//   i_rf_rd_data/i_rf_rd_valid       reg-file read data and its valid
//   o_alu_en/o_alu_fun               ALU start pulse and function code
//   i_alu_out/i_alu_valid            ALU result (2*WIDTH) and its valid
//   o_tx_data/o_tx_valid/i_tx_busy   byte to UART TX, valid, TX busy
//   o_timeout                        1-cycle pulse on wait-state abort
// Modports: master = sequencer, slave = surrounding system.
interface sys_ctrl_cmd_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int FUN_W  = 4
);
  logic [WIDTH-1:0]   i_rx_data;
  logic               i_rx_valid;
  logic               o_rf_wr_en;
  logic               o_rf_rd_en;
  logic [ADDR_W-1:0]  o_rf_addr;
  logic [WIDTH-1:0]   o_rf_wr_data;
  logic [WIDTH-1:0]   i_rf_rd_data;
  logic               i_rf_rd_valid;
  logic               o_alu_en;
  logic [FUN_W-1:0]   o_alu_fun;
  logic [2*WIDTH-1:0] i_alu_out;
  logic               i_alu_valid;
  logic [WIDTH-1:0]   o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_busy;
  logic               o_timeout;

  modport master (
    input  i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid,
           i_alu_out, i_alu_valid, i_tx_busy,
    output o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_wr_data,
           o_alu_en, o_alu_fun, o_tx_data, o_tx_valid, o_timeout
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_rf_rd_data, i_rf_rd_valid,
           i_alu_out, i_alu_valid, i_tx_busy,
    input  o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_wr_data,
           o_alu_en, o_alu_fun, o_tx_data, o_tx_valid, o_timeout
  );

endinterface

// File: rtl/sys_ctrl_cmd.sv
// rtl/sys_ctrl_cmd.sv - framed byte-command sequencer for reg file, ALU and UART TX
// Purpose: decodes AA (write), BB (read), CC (ALU with operands) and DD (ALU, no
//   operands) frames from the RX byte stream, issues single-cycle reg-file and ALU
//   pulses, and returns read data / ALU results as bytes to UART TX.
// Ports:
//   i_clk     system clock
//   i_arst_n  asynchronous active-low reset
//   bus       sys_ctrl_cmd_if.master (RX, reg-file, ALU, TX and timeout signals)
module sys_ctrl_cmd
  import sys_ctrl_cmd_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int FUN_W   = 4,
  parameter int TIMEOUT = 255,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_arst_n,
  sys_ctrl_cmd_if.master    bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic               rf_wr_en_q, rf_wr_en_d;
  logic               rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_W-1:0]  rf_addr_q, rf_addr_d;
  logic [WIDTH-1:0]   rf_wr_data_q, rf_wr_data_d;
  logic               alu_en_q, alu_en_d;
  logic [FUN_W-1:0]   alu_fun_q, alu_fun_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               two_q, two_d;
  logic [WIDTH-1:0]   tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q      <= S_IDLE;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
      alu_en_q     <= 1'b0;
      alu_fun_q    <= '0;
      res_hi_q     <= '0;
      two_q        <= 1'b0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      timeout_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      alu_en_q     <= alu_en_d;
      alu_fun_q    <= alu_fun_d;
      res_hi_q     <= res_hi_d;
      two_q        <= two_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      timeout_q    <= timeout_d;
      cnt_q        <= cnt_d;
    end
  end

  // All outputs are registered: a pulse decided in cycle N appears in cycle N+1.
  // Bytes arriving in wait/TX states fall through to the defaults and are dropped.
  always_comb begin
    state_d      = state_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    alu_en_d     = 1'b0;
    alu_fun_d    = alu_fun_q;
    res_hi_d     = res_hi_q;
    two_d        = two_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    timeout_d    = 1'b0;
    cnt_d        = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_rx_valid) begin
          case (bus.i_rx_data)
            CMD_WR:      state_d = S_WR_ADDR;
            CMD_RD:      state_d = S_RD_ADDR;
            CMD_ALU_OP:  state_d = S_ALU_A;
            CMD_ALU_NOP: state_d = S_ALU_FUN;
            default:     state_d = S_IDLE;
          endcase
        end
      end

      S_WR_ADDR: begin
        if (bus.i_rx_valid) begin
          rf_addr_d = bus.i_rx_data[ADDR_W-1:0];
          state_d   = S_WR_DATA;
        end
      end

      S_WR_DATA: begin
        if (bus.i_rx_valid) begin
          rf_wr_data_d = bus.i_rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_RD_ADDR: begin
        if (bus.i_rx_valid) begin
          rf_addr_d  = bus.i_rx_data[ADDR_W-1:0];
          rf_rd_en_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (bus.i_rf_rd_valid) begin
          tx_data_d  = bus.i_rf_rd_data;
          tx_valid_d = 1'b1;
          two_d      = 1'b0;
          state_d    = S_TX_LO;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Operand bytes go straight into reg0/reg1 where the ALU reads them.
      S_ALU_A: begin
        if (bus.i_rx_valid) begin
          rf_addr_d    = '0;
          rf_wr_data_d = bus.i_rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_ALU_B;
        end
      end

      S_ALU_B: begin
        if (bus.i_rx_valid) begin
          rf_addr_d    = ADDR_W'(1);
          rf_wr_data_d = bus.i_rx_data;
          rf_wr_en_d   = 1'b1;
          state_d      = S_ALU_FUN;
        end
      end

      S_ALU_FUN: begin
        if (bus.i_rx_valid) begin
          alu_fun_d = bus.i_rx_data[FUN_W-1:0];
          alu_en_d  = 1'b1;
          cnt_d     = '0;
          state_d   = S_ALU_WAIT;
        end
      end

      S_ALU_WAIT: begin
        if (bus.i_alu_valid) begin
          tx_data_d  = bus.i_alu_out[WIDTH-1:0];
          res_hi_d   = bus.i_alu_out[2*WIDTH-1:WIDTH];
          tx_valid_d = 1'b1;
          two_d      = 1'b1;
          state_d    = S_TX_LO;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // tx_valid stays high across the LO->HI hand-over, so the high byte is
      // presented in the cycle right after the low byte is accepted.
      S_TX_LO: begin
        if (!bus.i_tx_busy) begin
          if (two_q) begin
            tx_data_d = res_hi_q;
            state_d   = S_TX_HI;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end

      S_TX_HI: begin
        if (!bus.i_tx_busy) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_rf_wr_en   = rf_wr_en_q;
  assign bus.o_rf_rd_en   = rf_rd_en_q;
  assign bus.o_rf_addr    = rf_addr_q;
  assign bus.o_rf_wr_data = rf_wr_data_q;
  assign bus.o_alu_en     = alu_en_q;
  assign bus.o_alu_fun    = alu_fun_q;
  assign bus.o_tx_data    = tx_data_q;
  assign bus.o_tx_valid   = tx_valid_q;
  assign bus.o_timeout    = timeout_q;

endmodule
